// File: rtl/ov5640_init_seq_if.sv
// Handshake bundle between the OV5640 init sequencer (master) and its init ROM / SCCB write master (slave).
interface ov5640_init_seq_if #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_q;
    logic                  sccb_req;
    logic [15:0]           sccb_reg;
    logic [7:0]            sccb_dat;
    logic                  sccb_done;
    logic                  sccb_nack;

    modport master (
        output rom_addr, sccb_req, sccb_reg, sccb_dat,
        input  rom_q, sccb_done, sccb_nack
    );

    modport slave (
        input  rom_addr, sccb_req, sccb_reg, sccb_dat,
        output rom_q, sccb_done, sccb_nack
    );
endinterface

// File: rtl/ov5640_init_seq.sv
// OV5640 power-up register sequencer: walks the init ROM and issues one SCCB write per entry.
// Optional macro OV5640_INIT_RETRY_EN re-issues a NACKed write up to RETRY_MAX extra times.
module ov5640_init_seq #(
    parameter int          DATA_WIDTH   = 24,
    parameter int          ADDR_WIDTH   = 8,
    parameter int          INIT_REG_NUM = 86,
    parameter logic [23:0] POWERUP_DLY  = 24'd480000,
    parameter logic [23:0] SOFT_RST_DLY = 24'd24000,
    parameter int          RETRY_MAX    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    ov5640_init_seq_if.master     bus,
    output logic                  busy,
    output logic                  init_done,
    output logic                  init_err,
    output logic [ADDR_WIDTH-1:0] err_idx
);

    typedef enum logic [3:0] {
        IDLE, PWR_WAIT, FETCH, LATCH, WRITE, RST_WAIT, NEXT, DONE, ERR
    } state_t;

    // A zero delay still costs one wait cycle, so the terminal count never underflows.
    localparam logic [23:0] PWR_LAST  = (POWERUP_DLY  == 24'd0) ? 24'd0 : POWERUP_DLY  - 24'd1;
    localparam logic [23:0] SRST_LAST = (SOFT_RST_DLY == 24'd0) ? 24'd0 : SOFT_RST_DLY - 24'd1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(INIT_REG_NUM - 1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] idx;
    logic [23:0]           cnt;
    logic                  cnt_hit;
    logic                  is_soft_rst;
    logic                  retry_exh;

    assign cnt_hit     = (state == PWR_WAIT) ? (cnt == PWR_LAST) : (cnt == SRST_LAST);
    assign is_soft_rst = (bus.sccb_reg == 16'h3008) && bus.sccb_dat[7];

`ifdef OV5640_INIT_RETRY_EN
    localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_MAX);
    logic [RW-1:0] retry_cnt;
    assign retry_exh = (retry_cnt == RETRY_LAST);
`else
    assign retry_exh = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nxt = PWR_WAIT;
            PWR_WAIT:        if (cnt_hit) state_nxt = FETCH;
            FETCH:           state_nxt = LATCH;
            LATCH:           state_nxt = WRITE;
            WRITE: begin
                if (bus.sccb_done) begin
                    if (bus.sccb_nack)    state_nxt = retry_exh ? ERR : LATCH;
                    else if (is_soft_rst) state_nxt = RST_WAIT;
                    else                  state_nxt = NEXT;
                end
            end
            RST_WAIT:        if (cnt_hit) state_nxt = NEXT;
            NEXT:            state_nxt = (idx == LAST_IDX) ? DONE : FETCH;
            default:         state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.sccb_req = (state == WRITE);
        busy         = !((state == IDLE) || (state == DONE) || (state == ERR));
        init_done    = (state == DONE);
        init_err     = (state == ERR);
    end

    // Index, delay counter, ROM address and the write payload latched for the SCCB master.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            cnt          <= '0;
            err_idx      <= '0;
            bus.rom_addr <= '0;
            bus.sccb_reg <= '0;
            bus.sccb_dat <= '0;
`ifdef OV5640_INIT_RETRY_EN
            retry_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        idx     <= '0;
                        cnt     <= '0;
                        err_idx <= '0;
                    end
                end
                PWR_WAIT, RST_WAIT: cnt <= cnt_hit ? 24'd0 : cnt + 24'd1;
                FETCH: begin
                    bus.rom_addr <= idx;
`ifdef OV5640_INIT_RETRY_EN
                    retry_cnt    <= '0;
`endif
                end
                LATCH: begin
                    bus.sccb_reg <= bus.rom_q[DATA_WIDTH-1 -: 16];
                    bus.sccb_dat <= bus.rom_q[7:0];
                end
                WRITE: begin
                    if (bus.sccb_done && bus.sccb_nack) begin
                        if (retry_exh) err_idx <= idx;
`ifdef OV5640_INIT_RETRY_EN
                        else           retry_cnt <= retry_cnt + 1'b1;
`endif
                    end
                end
                NEXT: if (idx != LAST_IDX) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ov5640_init_seq.sv
// Directed bench for ov5640_init_seq: 4-entry stub ROM plus an SCCB slave model that answers 5 cycles after each request.
module tb_ov5640_init_seq;
    localparam int AW = 8;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, init_done, init_err;
    logic [AW-1:0] err_idx;

    ov5640_init_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ov5640_init_seq #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_REG_NUM(4),
        .POWERUP_DLY(24'd10), .SOFT_RST_DLY(24'd20), .RETRY_MAX(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .busy(busy), .init_done(init_done), .init_err(init_err), .err_idx(err_idx)
    );

    always #5 clk = ~clk;

    logic [23:0] rom_tbl [4] = '{24'h300882, 24'h310303, 24'h430003, 24'h501f03};
    assign bus.rom_q = rom_tbl[bus.rom_addr[1:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          start_cyc = 0;
    int          ack_cnt = 0;
    int          req_n = 0;
    int          stab_err = 0;
    int          nack_used = 0;
    int          nack_base = 0;
    int          nack_limit = 0;
    logic [15:0] nack_reg = 16'hffff;
    logic        force_done = 1'b0;
    logic [23:0] cur;
    logic [23:0] req_val [64];
    int          req_cyc [64];
    int          ack_cyc [64];

    // SCCB slave: logs each request, watches payload stability, answers on the 5th cycle of req.
    always @(negedge clk) begin
        bus.sccb_done = force_done;
        bus.sccb_nack = force_done;
        if (!rst_n) begin
            ack_cnt = 0;
        end else if (bus.sccb_req) begin
            if (ack_cnt == 0) begin
                cur = {bus.sccb_reg, bus.sccb_dat};
                if (req_n < 64) begin
                    req_val[req_n] = cur;
                    req_cyc[req_n] = cyc;
                end
                req_n++;
            end else if ({bus.sccb_reg, bus.sccb_dat} !== cur) begin
                stab_err++;
            end
            ack_cnt++;
            if (ack_cnt == 5) begin
                bus.sccb_done = 1'b1;
                bus.sccb_nack = 1'b0;
                if (bus.sccb_reg == nack_reg && (nack_used - nack_base) < nack_limit) begin
                    bus.sccb_nack = 1'b1;
                    nack_used++;
                end
                if (req_n <= 64) ack_cyc[req_n-1] = cyc + 1;
                ack_cnt = 0;
            end
        end else begin
            ack_cnt = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitEnd(input int limit);
        int n;
        n = 0;
        while (!(init_done || init_err) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput("run_finished", 32'(init_done | init_err), 1);
    endtask

    task automatic checkFullRun(input int base);
        checkOutput("req_count", req_n - base, 4);
        for (int i = 0; i < 4; i++) checkOutput("write_payload", req_val[base+i], rom_tbl[i]);
        checkOutput("first_req_delay", req_cyc[base] - start_cyc, 12);
        checkOutput("srst_gap_ge20", 32'((req_cyc[base+1] - ack_cyc[base]) >= 20), 1);
        checkOutput("normal_gap", req_cyc[base+2] - ack_cyc[base+1], 3);
        checkOutput("done_flag", init_done, 1);
        checkOutput("done_busy", busy, 0);
        checkOutput("done_err", init_err, 0);
    endtask

    initial begin
        int base;
        int n;

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", init_done, 0);
        checkOutput("rst_err", init_err, 0);
        checkOutput("rst_req", bus.sccb_req, 0);
        checkOutput("rst_rom_addr", bus.rom_addr, 0);
        rst_n = 1'b1;

        $display("[TB] nominal run with start/done abuse during power-up wait");
        base = req_n;
        applyStimulus();
        checkOutput("busy_after_start", busy, 1);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1 force_done = 1'b1;
        @(posedge clk);
        #1 force_done = 1'b0;
        waitEnd(600);
        checkFullRun(base);
        checkOutput("final_rom_addr", bus.rom_addr, 3);

        $display("[TB] restart from DONE");
        base = req_n;
        applyStimulus();
        checkOutput("restart_done_clr", init_done, 0);
        checkOutput("restart_busy", busy, 1);
        waitEnd(600);
        checkFullRun(base);

`ifdef OV5640_INIT_RETRY_EN
        $display("[TB] retry: 3103 NACKs twice then ACKs");
        base = req_n;
        nack_base = nack_used;
        nack_reg = 16'h3103;
        nack_limit = 2;
        applyStimulus();
        waitEnd(800);
        checkOutput("retry_req_count", req_n - base, 6);
        for (int i = 1; i < 4; i++) checkOutput("retry_payload", req_val[base+i], 24'h310303);
        checkOutput("retry_done", init_done, 1);

        $display("[TB] retry: 3103 NACKs three times");
        base = req_n;
        nack_base = nack_used;
        nack_limit = 3;
        applyStimulus();
        waitEnd(800);
        checkOutput("retry_err", init_err, 1);
        checkOutput("retry_err_idx", err_idx, 1);
        checkOutput("retry_err_reqs", req_n - base, 4);
`else
        $display("[TB] NACK on third entry");
        base = req_n;
        nack_base = nack_used;
        nack_reg = 16'h4300;
        nack_limit = 1;
        applyStimulus();
        waitEnd(600);
        checkOutput("nack_err", init_err, 1);
        checkOutput("nack_err_idx", err_idx, 2);
        checkOutput("nack_no_done", init_done, 0);
        checkOutput("nack_busy", busy, 0);
        repeat (40) @(negedge clk);
        checkOutput("nack_req_count", req_n - base, 3);
`endif
        nack_limit = 0;

        $display("[TB] reset during WRITE");
        applyStimulus();
        n = 0;
        while (!bus.sccb_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("req_seen", bus.sccb_req, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_req", bus.sccb_req, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_reg", bus.sccb_reg, 0);
        checkOutput("arst_dat", bus.sccb_dat, 0);
        checkOutput("arst_rom_addr", bus.rom_addr, 0);
        checkOutput("arst_err_flag", init_err, 0);
        checkOutput("arst_err_idx", err_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        base = req_n;
        applyStimulus();
        waitEnd(600);
        checkFullRun(base);
        checkOutput("payload_stable", stab_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ov5640_init_seq.md
Name: ov5640_init_seq

Overview:
- Sequences the OV5640 register initialisation table after power-up.
- Fetches each 24-bit {reg_addr[15:0], data[7:0]} entry from the synchronous init ROM (1-cycle read latency) and hands it to the SCCB write master one transaction at a time.
- Inserts the power-up and post-soft-reset delays the sensor requires.
- Reports done or error to the camera top level, which holds the DVP capture path until done.

Parameters:
- DATA_WIDTH, 24, ROM word width: {16-bit register address, 8-bit data}.
- ADDR_WIDTH, 8, ROM address width.
- INIT_REG_NUM, 86, number of valid table entries (indices 0..INIT_REG_NUM-1).
- POWERUP_DLY, 24'd480000, clk cycles to wait after start before the first write (20 ms at 24 MHz).
- SOFT_RST_DLY, 24'd24000, clk cycles to wait after a write of 0x3008 with bit7=1 (1 ms at 24 MHz).
- RETRY_MAX, 2, extra attempts per entry on NACK (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a sequence when idle, ignored otherwise.
- rom_addr  out  ADDR_WIDTH  init ROM address (registered).
- rom_q  in  DATA_WIDTH  init ROM data, valid 1 cycle after rom_addr changes.
- sccb_req  out  1  write request, held until sccb_done.
- sccb_reg  out  16  register address for the current write.
- sccb_dat  out  8  data byte for the current write.
- sccb_done  in  1  one-cycle pulse: transaction finished.
- sccb_nack  in  1  qualified by sccb_done: slave did not acknowledge.
- busy  out  1  high from start acceptance until DONE or ERR.
- init_done  out  1  sticky high after the last entry is acknowledged.
- init_err  out  1  sticky high on an unrecovered NACK.
- err_idx  out  ADDR_WIDTH  table index of the failing entry.

Behaviour:
- Reset values: all outputs 0, state IDLE, index 0, delay counter 0. Reset takes effect at any time, including mid-transaction.
- States: IDLE, PWR_WAIT, FETCH, LATCH, WRITE, RST_WAIT, NEXT, DONE, ERR.
- IDLE: on start=1, go to PWR_WAIT, busy=1, clear init_done/init_err/err_idx, index=0, counter=0.
- PWR_WAIT: counter increments each cycle; when counter==POWERUP_DLY-1, go to FETCH and clear the counter. POWERUP_DLY=0 is treated as 1.
- FETCH: rom_addr<=index; go to LATCH.
- LATCH: ROM output settles this cycle. At the end of the cycle capture sccb_reg<=rom_q[23:8] and sccb_dat<=rom_q[7:0], set sccb_req<=1, go to WRITE.
  - sccb_req is therefore first high 2 cycles after FETCH is entered.
- WRITE: sccb_req, sccb_reg and sccb_dat stay stable until sccb_done. On sccb_done, sccb_req<=0 in the same edge.
  - done with nack=0, and the entry is 0x3008 with bit7=1: go to RST_WAIT.
  - done with nack=0, otherwise: go to NEXT.
  - done with nack=1: go to ERR with err_idx<=index (base build).
- RST_WAIT: count SOFT_RST_DLY cycles, same rule as PWR_WAIT, then go to NEXT.
- NEXT:
  - if index==INIT_REG_NUM-1, go to DONE;
  - else index<=index+1 and go to FETCH.
  - Index comparison is at ADDR_WIDTH bits; no wrap past INIT_REG_NUM-1.
- DONE: init_done=1, busy=0; remain here. A start pulse restarts the sequence exactly as from IDLE (clears init_done).
- ERR: init_err=1, busy=0; remain here. A start pulse restarts the sequence (clears init_err).
- sccb_done outside WRITE is ignored. sccb_nack is ignored unless sccb_done=1.
- start while busy is ignored.
- Exactly one request per entry (base build); requests never overlap.

Optional Feature:
- Macro: OV5640_INIT_RETRY_EN.
- Defined:
  - a NACK in WRITE increments a per-entry retry counter (reset to 0 in FETCH) and returns to LATCH, so a fresh request is issued after 1 gap cycle;
  - after RETRY_MAX retries that all NACK, go to ERR;
  - a successful retry proceeds normally.
- Undefined: the retry counter is absent; the first NACK goes to ERR.

Test Plan:
- Nominal run: stub ROM with INIT_REG_NUM=4, POWERUP_DLY=10, SOFT_RST_DLY=20, entries {3008_82, 3103_03, 4300_03, 501f_03}, SCCB model acking 5 cycles after req.
  - First sccb_req rises 12 cycles after the start edge.
  - 4 writes in order with matching reg/dat.
  - Gap after the 3008_82 ack is at least 20 cycles.
  - Then init_done=1 and busy=0.
- NACK on the 3rd entry (base build): init_err=1, err_idx=2, no further requests, init_done=0.
- Retry (macro defined, RETRY_MAX=2): entry 1 NACKs twice then ACKs, giving 3 requests for 3103_03 and init_done=1. NACKing 3 times gives init_err=1 and err_idx=1.
- Protocol abuse:
  - start pulsed while busy: no restart.
  - spurious sccb_done in PWR_WAIT: ignored.
  - sccb_reg/sccb_dat must not change while sccb_req=1.
- Reset mid-WRITE: drop rst_n while sccb_req=1. All outputs are 0 asynchronously; after release and a new start, the sequence restarts from index 0.
- Restart from DONE: pulse start, init_done clears within 1 cycle, and the full sequence repeats identically.
